// File: rtl/hadamard_seq_if.sv
// Handshake and data bundle between the Hadamard frame sequencer and its environment
// (stage buffer / twiddle ROM, datapath, and result consumer).
interface hadamard_seq_if #(
    parameter int formatWidth = 9,
    parameter int ADDR_W      = 6
);
    logic                     frame_start;
    logic [ADDR_W:0]          frame_len;
    logic [ADDR_W-1:0]        tw_base;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_addr;
    logic [ADDR_W-1:0]        tw_addr;
    logic                     hd_start;
    logic                     hd_in_valid;
    logic [formatWidth*4-1:0] hd_out_real;
    logic [formatWidth*4-1:0] hd_out_imag;
    logic                     out_valid;
    logic                     out_ready;
    logic [formatWidth*4-1:0] out_real;
    logic [formatWidth*4-1:0] out_imag;
    logic [ADDR_W-1:0]        out_tag;
    logic                     busy;
    logic                     frame_done;
    logic                     err_ovf;

    modport master (
        input  frame_start, frame_len, tw_base, hd_out_real, hd_out_imag, out_ready,
        output rd_en, rd_addr, tw_addr, hd_start, hd_in_valid,
               out_valid, out_real, out_imag, out_tag, busy, frame_done, err_ovf
    );

    modport slave (
        output frame_start, frame_len, tw_base, hd_out_real, hd_out_imag, out_ready,
        input  rd_en, rd_addr, tw_addr, hd_start, hd_in_valid,
               out_valid, out_real, out_imag, out_tag, busy, frame_done, err_ovf
    );
endinterface

// File: rtl/hadamard_seq.sv
// Frame sequencer for the 4-lane Hadamard/twiddle pipeline: credit-gated issue, valid/tag
// tracking, output FIFO. Optional HADSEQ_PERF_EN adds perf_stall / perf_frames counters.
module hadamard_seq #(
    parameter int formatWidth = 9,
    parameter int ADDR_W      = 6,
    parameter int LATENCY     = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic           clk,
    input  logic           rst,
    hadamard_seq_if.master bus
`ifdef HADSEQ_PERF_EN
    ,
    output logic [15:0]    perf_stall,
    output logic [15:0]    perf_frames
`endif
);
    localparam int DW    = formatWidth * 4;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                        state_reg, state_next;
    logic [ADDR_W:0]               len_reg;
    logic [ADDR_W:0]               issue_idx_reg;
    logic [ADDR_W-1:0]             tw_base_reg;
    logic [CNT_W-1:0]              inflight_reg;
    logic [CNT_W-1:0]              count_reg;
    logic [PTR_W-1:0]              wr_ptr_reg;
    logic [PTR_W-1:0]              rd_ptr_reg;
    logic                          err_ovf_reg;
    logic                          first_reg;
    logic [LATENCY:0]              vld_reg;
    logic [LATENCY:0][ADDR_W-1:0]  tag_reg;

    logic [DW-1:0]     mem_real [FIFO_DEPTH];
    logic [DW-1:0]     mem_imag [FIFO_DEPTH];
    logic [ADDR_W-1:0] mem_tag  [FIFO_DEPTH];

    logic credit_ok, issue, last_issue, capture, full, push, pop;

    // Credit covers every group already issued, so a capture can never find the FIFO full.
    always_comb begin
        credit_ok  = ({1'b0, inflight_reg} + {1'b0, count_reg}) < (CNT_W + 1)'(FIFO_DEPTH);
        issue      = (state_reg == RUN) && credit_ok;
        last_issue = issue && ((issue_idx_reg + (ADDR_W + 1)'(1)) == len_reg);
        capture    = vld_reg[LATENCY];
        full       = (count_reg == CNT_W'(FIFO_DEPTH));
        push       = capture && !full;
        pop        = (count_reg != '0) && bus.out_ready;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.frame_start) state_next = (bus.frame_len == '0) ? DONE : RUN;
            RUN:     if (last_issue) state_next = DRAIN;
            DRAIN:   if (inflight_reg == '0 && count_reg == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            issue_idx_reg <= '0;
            tw_base_reg   <= '0;
            inflight_reg  <= '0;
            err_ovf_reg   <= 1'b0;
            first_reg     <= 1'b0;
            vld_reg       <= '0;
            tag_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && bus.frame_start) begin
                len_reg       <= bus.frame_len;
                tw_base_reg   <= bus.tw_base;
                issue_idx_reg <= '0;
            end else if (issue) begin
                issue_idx_reg <= issue_idx_reg + (ADDR_W + 1)'(1);
            end
            // Stage 0 mirrors the 1-cycle buffer read; the tail lines up with datapath output.
            vld_reg   <= {vld_reg[LATENCY-1:0], issue};
            tag_reg   <= {tag_reg[LATENCY-1:0], issue_idx_reg[ADDR_W-1:0]};
            first_reg <= issue && (issue_idx_reg == '0);
            if (issue && !capture)
                inflight_reg <= inflight_reg + CNT_W'(1);
            else if (!issue && capture)
                inflight_reg <= inflight_reg - CNT_W'(1);
            if (capture && full)
                err_ovf_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)
                count_reg <= count_reg + CNT_W'(1);
            else if (!push && pop)
                count_reg <= count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_real[wr_ptr_reg] <= bus.hd_out_real;
            mem_imag[wr_ptr_reg] <= bus.hd_out_imag;
            mem_tag[wr_ptr_reg]  <= tag_reg[LATENCY];
        end
    end

    assign bus.rd_en       = issue;
    assign bus.rd_addr     = issue_idx_reg[ADDR_W-1:0];
    assign bus.tw_addr     = tw_base_reg + issue_idx_reg[ADDR_W-1:0];
    assign bus.hd_in_valid = vld_reg[0];
    assign bus.hd_start    = vld_reg[0] & first_reg;
    assign bus.out_valid   = (count_reg != '0);
    // Head is gated so stale storage never leaks out while the FIFO is empty.
    assign bus.out_real    = bus.out_valid ? mem_real[rd_ptr_reg] : '0;
    assign bus.out_imag    = bus.out_valid ? mem_imag[rd_ptr_reg] : '0;
    assign bus.out_tag     = bus.out_valid ? mem_tag[rd_ptr_reg]  : '0;
    assign bus.busy        = (state_reg != IDLE);
    assign bus.frame_done  = (state_reg == DONE);
    assign bus.err_ovf     = err_ovf_reg;

`ifdef HADSEQ_PERF_EN
    logic [15:0] perf_stall_reg, perf_frames_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_reg  <= '0;
            perf_frames_reg <= '0;
        end else begin
            if (state_reg == RUN && !credit_ok && perf_stall_reg != 16'hFFFF)
                perf_stall_reg <= perf_stall_reg + 16'd1;
            if (state_reg == DONE)
                perf_frames_reg <= perf_frames_reg + 16'd1;
        end
    end

    assign perf_stall  = perf_stall_reg;
    assign perf_frames = perf_frames_reg;
`endif
endmodule

// File: tb/tb_hadamard_seq.sv
// Randomized scoreboard bench for hadamard_seq: frames are queued as expected results
// when started, and a free-running monitor checks addresses, strobes and FIFO output.
module tb_hadamard_seq;
    localparam int FW  = 9;
    localparam int AW  = 6;
    localparam int LAT = 4;
    localparam int FD  = 8;
    localparam int DW  = FW * 4;

    typedef struct {
        logic [AW-1:0] tag;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hadamard_seq_if #(.formatWidth(FW), .ADDR_W(AW)) bus ();

`ifdef HADSEQ_PERF_EN
    logic [15:0] perf_stall, perf_frames;
`endif

    hadamard_seq #(.formatWidth(FW), .ADDR_W(AW), .LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef HADSEQ_PERF_EN
        ,
        .perf_stall  (perf_stall),
        .perf_frames (perf_frames)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    int   tw_seen[$];
    logic [DW-1:0] src_re [64];
    logic [DW-1:0] src_im [64];
    int   cur_len = 0, exp_rd_idx = 0, exp_tw_base = 0, rd_count = 0, done_cnt = 0;
    int   first_rd_cyc = -1, first_ov_cyc = -1;
    logic rand_mode = 1'b0, ready_fix = 1'b0;

    function automatic logic [DW-1:0] rnd();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Environment model: 1-cycle buffer read, then a LATENCY-deep datapath; noise when invalid.
    logic [DW-1:0] buf_re, buf_im, noise_re, noise_im;
    logic          pv  [LAT];
    logic [DW-1:0] pre [LAT];
    logic [DW-1:0] pim [LAT];
    always @(posedge clk) begin
        if (bus.rd_en) begin
            buf_re <= src_re[bus.rd_addr];
            buf_im <= src_im[bus.rd_addr];
        end
        pv[0]    <= bus.hd_in_valid;
        pre[0]   <= buf_re;
        pim[0]   <= buf_im;
        for (int k = 1; k < LAT; k++) begin
            pv[k]  <= pv[k-1];
            pre[k] <= pre[k-1];
            pim[k] <= pim[k-1];
        end
        noise_re <= rnd();
        noise_im <= rnd();
    end
    assign bus.hd_out_real = pv[LAT-1] ? pre[LAT-1] : noise_re;
    assign bus.hd_out_imag = pv[LAT-1] ? pim[LAT-1] : noise_im;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fix;
        end
    end

    // Monitor: read strobes, datapath strobes, FIFO pops and frame completion.
    initial begin
        logic        prev_rd;
        logic [AW-1:0] prev_idx;
        exp_t        e;
        prev_rd  = 1'b0;
        prev_idx = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_rd = 1'b0;
            end else begin
                if (bus.hd_in_valid || bus.hd_start || prev_rd) begin
                    check("hd_in_valid", 64'(bus.hd_in_valid), 64'(prev_rd));
                    check("hd_start", 64'(bus.hd_start), 64'(prev_rd && prev_idx == '0));
                end
                if (bus.rd_en) begin
                    check("rd_addr", 64'(bus.rd_addr), 64'(exp_rd_idx));
                    check("tw_addr", 64'(bus.tw_addr), 64'((exp_tw_base + exp_rd_idx) % 64));
                    tw_seen.push_back(int'(bus.tw_addr));
                    if (rd_count == 0) first_rd_cyc = cyc;
                    exp_rd_idx++;
                    rd_count++;
                end
                prev_rd  = bus.rd_en;
                prev_idx = bus.rd_addr;
                if (bus.out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop actual tag=%0d required=none", bus.out_tag);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_tag", 64'(bus.out_tag), 64'(e.tag));
                        check("out_real", 64'(bus.out_real), 64'(e.re));
                        check("out_imag", 64'(bus.out_imag), 64'(e.im));
                        $display("pop tag=%0d real=%0h imag=%0h", bus.out_tag, bus.out_real, bus.out_imag);
                    end
                end
                if (bus.frame_done) begin
                    done_cnt++;
                    check("done_queue_empty", 64'(exp_q.size()), 64'd0);
                    check("done_all_issued", 64'(rd_count), 64'(cur_len));
                end
            end
        end
    end

    // Called at posedge+1; expected results for the whole frame are queued up front.
    task automatic start_frame(input int len, input int base);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            src_re[i] = rnd();
            src_im[i] = rnd();
            e.tag = AW'(i);
            e.re  = src_re[i];
            e.im  = src_im[i];
            exp_q.push_back(e);
        end
        cur_len      = len;
        exp_rd_idx   = 0;
        exp_tw_base  = base;
        rd_count     = 0;
        first_rd_cyc = -1;
        first_ov_cyc = -1;
        tw_seen.delete();
        $display("frame start len=%0d tw_base=%0d", len, base);
        bus.frame_len   = (AW + 1)'(len);
        bus.tw_base     = AW'(base);
        bus.frame_start = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start;
        start = done_cnt;
        for (int i = 0; i < budget && done_cnt == start; i++) @(posedge clk);
        #1;
        check("frame_done_seen", 64'(done_cnt != start), 64'd1);
    endtask

    task automatic check_outputs_zero(input string ctx);
        check({ctx, "_rd_en"}, 64'(bus.rd_en), 64'd0);
        check({ctx, "_hd_in_valid"}, 64'(bus.hd_in_valid), 64'd0);
        check({ctx, "_hd_start"}, 64'(bus.hd_start), 64'd0);
        check({ctx, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({ctx, "_busy"}, 64'(bus.busy), 64'd0);
        check({ctx, "_frame_done"}, 64'(bus.frame_done), 64'd0);
        check({ctx, "_err_ovf"}, 64'(bus.err_ovf), 64'd0);
        check({ctx, "_addrs"}, {40'd0, bus.rd_addr, bus.tw_addr, bus.out_tag}, 64'd0);
        check({ctx, "_out_real"}, 64'(bus.out_real), 64'd0);
    endtask

    initial begin
        int d0, base, len;
        int exp_tw[4];
        bus.frame_start = 1'b0;
        bus.frame_len   = '0;
        bus.tw_base     = '0;

        // Power-on reset
        #2 rst = 1'b0;
        #1 check_outputs_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Basic frame: 4 groups from tw_base 10, consumer always ready
        ready_fix = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        d0 = done_cnt;
        start_frame(4, 10);
        wait_done(100);
        check("basic_latency", 64'(first_ov_cyc - first_rd_cyc), 64'(LAT + 2));
        repeat (5) @(posedge clk);
        #1;
        check("basic_done_once", 64'(done_cnt - d0), 64'd1);
        check("basic_idle", 64'(bus.busy), 64'd0);

        // Back-pressure: credit limits issue to FIFO_DEPTH groups
        ready_fix = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start_frame(20, int'($urandom_range(0, 63)));
        repeat (40) @(posedge clk);
        #1;
        check("bp_issued", 64'(rd_count), 64'(FD));
        check("bp_rd_held", 64'(bus.rd_en), 64'd0);
        check("bp_out_valid", 64'(bus.out_valid), 64'd1);
        check("bp_err_ovf", 64'(bus.err_ovf), 64'd0);
        check("bp_busy", 64'(bus.busy), 64'd1);
        ready_fix = 1'b1;
        wait_done(300);
        check("bp_total_issued", 64'(rd_count), 64'd20);

        // Empty frame
        repeat (2) @(posedge clk);
        #1;
        d0 = done_cnt;
        start_frame(0, 5);
        check("empty_done_next", 64'(bus.frame_done), 64'd1);
        @(posedge clk);
        #1;
        check("empty_done_pulse", 64'(bus.frame_done), 64'd0);
        check("empty_idle", 64'(bus.busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("empty_no_reads", 64'(rd_count), 64'd0);
        check("empty_done_count", 64'(done_cnt - d0), 64'd1);

        // frame_start while running is ignored
        d0 = done_cnt;
        start_frame(6, int'($urandom_range(0, 63)));
        repeat (2) @(posedge clk);
        #1;
        bus.frame_len   = 7'd2;
        bus.frame_start = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_start = 1'b0;
        wait_done(200);
        check("ignore_issued", 64'(rd_count), 64'd6);
        repeat (10) @(posedge clk);
        #1;
        check("ignore_done_count", 64'(done_cnt - d0), 64'd1);
        check("ignore_idle", 64'(bus.busy), 64'd0);

        // Asynchronous reset with 3 groups in flight
        ready_fix = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start_frame(10, int'($urandom_range(0, 63)));
        for (int i = 0; i < 20 && rd_count < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("rst_inflight", 64'(rd_count), 64'd3);
        rst = 1'b0;
        #1 check_outputs_zero("midreset");
        exp_q.delete();
        cur_len = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("post_reset_fifo_empty", 64'(bus.out_valid), 64'd0);
        check("post_reset_idle", 64'(bus.busy), 64'd0);
        ready_fix = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        start_frame(1, int'($urandom_range(0, 63)));
        wait_done(100);

        // Twiddle address wrap
        start_frame(4, 62);
        wait_done(100);
        exp_tw = '{62, 63, 0, 1};
        check("tw_wrap_count", 64'(tw_seen.size()), 64'd4);
        for (int i = 0; i < 4 && i < tw_seen.size(); i++)
            check("tw_wrap_seq", 64'(tw_seen[i]), 64'(exp_tw[i]));

        // Random frames with random consumer back-pressure
        rand_mode = 1'b1;
        for (int f = 0; f < 4; f++) begin
            len  = int'($urandom_range(1, 40));
            base = int'($urandom_range(0, 63));
            repeat (2) @(posedge clk);
            #1;
            start_frame(len, base);
            wait_done(2000);
        end
        rand_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("final_err_ovf", 64'(bus.err_ovf), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
